gaus_window_sequencer: RTL

- Frame-level controller for the 5x5 Gaussian window path.
- Issues the column-shift strobes that load the shift buffers and the hold strobes that latch each complete window into the hold registers.
- Tracks the centre-pixel address, skipping a BORDER-pixel frame on all sides.
- Paces holds on a BEATS-cycle cadence and stalls on upstream/downstream flow control.

---
 rtl/gaus_window_sequencer_if.sv | 25 ++
 rtl/gaus_window_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gaus_window_sequencer_if.sv
// Handshake and strobe bundle between the Gaussian window sequencer and its datapath.
// The sequencer connects through master and the datapath/bench through slave.
interface gaus_window_sequencer_if #(
  parameter int unsigned PIXW = 24
) ();
  logic            start;
  logic            srcValid;
  logic            dstReady;
  logic            shiftEn;
  logic            holdEn;
  logic [PIXW-1:0] pixelAddr;
  logic            rowStart;
  logic            busy;
  logic            frameDone;

  modport master (
    input  start, srcValid, dstReady,
    output shiftEn, holdEn, pixelAddr, rowStart, busy, frameDone
  );

  modport slave (
    output start, srcValid, dstReady,
    input  shiftEn, holdEn, pixelAddr, rowStart, busy, frameDone
  );
endinterface

// File: rtl/gaus_window_sequencer.sv
// Frame controller for the 5x5 Gaussian window path: primes the shift buffers per row,
// then paces window holds on a BEATS cadence under src/dst flow control.
module gaus_window_sequencer #(
  parameter int unsigned IMGW   = 384,
  parameter int unsigned IMGH   = 256,
  parameter int unsigned BORDER = 2,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned PAUSE  = 1,
  parameter int unsigned PIXW   = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  gaus_window_sequencer_if.master       bus
);

  localparam int unsigned Win     = 2 * BORDER + 1;
  localparam int unsigned LastCol = IMGW - 2 * BORDER - 1;
  localparam int unsigned LastRow = IMGH - 2 * BORDER - 1;
  localparam int unsigned ColW    = $clog2(IMGW);
  localparam int unsigned RowW    = $clog2(IMGH);
  localparam int unsigned BeatW   = $clog2(BEATS + 1);
  localparam int unsigned PrimeW  = $clog2(Win + 1);
  localparam int unsigned PauseW  = $clog2(PAUSE + 1);

  // The full image address range must fit in PIXW bits.
  if (longint'(IMGW) * longint'(IMGH) > (longint'(1) << PIXW)) begin : gen_addr_check
    $error("gaus_window_sequencer: IMGW*IMGH overflows PIXW");
  end

  typedef enum logic [2:0] {StIdle, StPrime, StRun, StRowEnd, StDone} state_e;

  state_e            stateQ, stateD;
  logic [RowW-1:0]   rowQ, rowD;
  logic [ColW-1:0]   colQ, colD;
  logic [BeatW-1:0]  beatQ, beatD;
  logic [PrimeW-1:0] primeQ, primeD;
  logic [PauseW-1:0] pauseQ, pauseD;
  logic [PIXW-1:0]   addrQ, addrD;
  logic              shiftQ, shiftD;
  logic              holdQ, holdD;
  logic              rowStartQ, rowStartD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic              lastCol, lastRow;

  assign lastCol = (colQ == ColW'(LastCol));
  assign lastRow = (rowQ == RowW'(LastRow));

  always_comb begin
    stateD    = stateQ;
    rowD      = rowQ;
    colD      = colQ;
    beatD     = beatQ;
    primeD    = primeQ;
    pauseD    = pauseQ;
    addrD     = addrQ;
    shiftD    = 1'b0;
    holdD     = 1'b0;
    rowStartD = 1'b0;
    doneD     = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          stateD    = StPrime;
          rowD      = '0;
          colD      = '0;
          primeD    = '0;
          rowStartD = 1'b1;
        end
      end
      StPrime: begin
        if (bus.srcValid) begin
          shiftD = 1'b1;
          if (primeQ == PrimeW'(Win - 1)) begin
            primeD = '0;
            beatD  = '0;
            stateD = StRun;
          end else begin
            primeD = primeQ + 1'b1;
          end
        end
      end
      StRun: begin
        if (beatQ != BeatW'(BEATS - 1)) begin
          beatD = beatQ + 1'b1;
        end else if (bus.dstReady && (bus.srcValid || lastCol)) begin
          holdD = 1'b1;
          addrD = (PIXW'(rowQ) + PIXW'(BORDER)) * PIXW'(IMGW) + PIXW'(colQ) + PIXW'(BORDER);
          beatD = '0;
          colD  = colQ + 1'b1;
          // The last window of a row needs no further column.
          if (lastCol) begin
            stateD = StRowEnd;
            pauseD = '0;
          end else begin
            shiftD = 1'b1;
          end
        end
      end
      StRowEnd: begin
        if (32'(pauseQ) + 32'd1 >= PAUSE) begin
          if (lastRow) begin
            stateD = StDone;
          end else begin
            rowD      = rowQ + 1'b1;
            colD      = '0;
            primeD    = '0;
            rowStartD = 1'b1;
            stateD    = StPrime;
          end
        end else begin
          pauseD = pauseQ + 1'b1;
        end
      end
      StDone: begin
        doneD  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
    busyD = (stateD != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StIdle;
      rowQ      <= '0;
      colQ      <= '0;
      beatQ     <= '0;
      primeQ    <= '0;
      pauseQ    <= '0;
      addrQ     <= '0;
      shiftQ    <= 1'b0;
      holdQ     <= 1'b0;
      rowStartQ <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      rowQ      <= rowD;
      colQ      <= colD;
      beatQ     <= beatD;
      primeQ    <= primeD;
      pauseQ    <= pauseD;
      addrQ     <= addrD;
      shiftQ    <= shiftD;
      holdQ     <= holdD;
      rowStartQ <= rowStartD;
      busyQ     <= busyD;
      doneQ     <= doneD;
    end
  end

  assign bus.shiftEn   = shiftQ;
  assign bus.holdEn    = holdQ;
  assign bus.pixelAddr = addrQ;
  assign bus.rowStart  = rowStartQ;
  assign bus.busy      = busyQ;
  assign bus.frameDone = doneQ;

endmodule
